// File: rtl/resample_packer.sv
// Captures free-running multi-channel resampler samples into a FIFO and serialises them onto a
// single-lane AXI-Stream with channel tag and tlast. Define RESAMPLE_PACKER_DROP_CNT_EN for the drop counter.
module resample_packer #(
   parameter int unsigned CH_NUM     = 2,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned FIFO_DEPTH = 16,
   localparam int unsigned CW        = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
   input  logic                                     clk_i,
   input  logic                                     rst_i,
   input  logic                                     en_i,
   input  logic                                     clr_i,
   input  logic [15:0]                              frame_len_i,
   input  logic                                     tvalid_i,
   input  logic signed [CH_NUM-1:0][DATA_WIDTH-1:0] tdata_i,
   output logic                                     m_tvalid_o,
   input  logic                                     m_tready_i,
   output logic signed [DATA_WIDTH-1:0]             m_tdata_o,
   output logic [CW-1:0]                            m_tuser_o,
   output logic                                     m_tlast_o,
   output logic                                     overflow_o,
   output logic [15:0]                              drop_cnt_o
);

   localparam int unsigned AW   = $clog2(FIFO_DEPTH);
   localparam int unsigned CNTW = AW + 1;

   typedef logic [CH_NUM-1:0][DATA_WIDTH-1:0] sample_t;
   typedef enum logic {IDLE, SEND} state_t;

   sample_t         mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CNTW-1:0] count;
   logic            full;
   logic            nonempty;
   logic            push;
   logic            drop;
   logic            pop;

   state_t          state;
   sample_t         hold;
   logic [CW-1:0]   ch_cnt;
   logic [15:0]     smp_cnt;
   logic [15:0]     len_q;

   logic                         hs;
   logic                         last_hs;
   logic                         busy_nxt;
   logic [CW-1:0]                ch_nxt;
   logic [15:0]                  smp_nxt;
   logic [15:0]                  len_nxt;
   sample_t                      hold_nxt;
   logic signed [DATA_WIDTH-1:0] data_nxt;
   logic                         tlast_nxt;

   // Fullness uses the registered count, so a same-cycle pop never rescues a write.
   assign full     = (count == CNTW'(FIFO_DEPTH));
   assign nonempty = (count != '0);
   assign push     = tvalid_i && en_i && !full;
   assign drop     = tvalid_i && en_i && full;

   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= tdata_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CNTW'(1);
            2'b01:   count <= count - CNTW'(1);
            default: count <= count;
         endcase
      end
   end

   // Next beat selection; outputs are loaded from these so they stay registered.
   always_comb begin
      hs       = (state == SEND) && m_tready_i;
      last_hs  = hs && (ch_cnt == CW'(CH_NUM - 1));
      pop      = nonempty && ((state == IDLE) || last_hs);
      busy_nxt = pop || ((state == SEND) && !last_hs);

      smp_nxt = smp_cnt;
      if (last_hs) smp_nxt = m_tlast_o ? 16'd0 : smp_cnt + 16'd1;

      len_nxt = len_q;
      if (pop && (smp_nxt == 16'd0)) len_nxt = (frame_len_i == 16'd0) ? 16'd1 : frame_len_i;

      ch_nxt = ch_cnt;
      if (pop || last_hs) ch_nxt = '0;
      else if (hs)        ch_nxt = ch_cnt + CW'(1);

      hold_nxt  = pop ? mem[rd_ptr] : hold;
      data_nxt  = busy_nxt ? hold_nxt[ch_nxt] : '0;
      tlast_nxt = busy_nxt && (ch_nxt == CW'(CH_NUM - 1)) && (smp_nxt == len_nxt - 16'd1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= IDLE;
         hold       <= '0;
         ch_cnt     <= '0;
         smp_cnt    <= '0;
         len_q      <= '0;
         m_tvalid_o <= 1'b0;
         m_tdata_o  <= '0;
         m_tuser_o  <= '0;
         m_tlast_o  <= 1'b0;
      end else begin
         case (state)
            IDLE:    if (nonempty) state <= SEND;
            SEND:    if (last_hs && !nonempty) state <= IDLE;
            default: state <= IDLE;
         endcase
         hold       <= hold_nxt;
         ch_cnt     <= ch_nxt;
         smp_cnt    <= smp_nxt;
         len_q      <= len_nxt;
         m_tvalid_o <= busy_nxt;
         m_tdata_o  <= data_nxt;
         m_tuser_o  <= busy_nxt ? ch_nxt : '0;
         m_tlast_o  <= tlast_nxt;
      end
   end

   // A drop in the same cycle as clr_i wins.
   always_ff @(posedge clk_i) begin
      if (rst_i)       overflow_o <= 1'b0;
      else if (drop)   overflow_o <= 1'b1;
      else if (clr_i)  overflow_o <= 1'b0;
   end

`ifdef RESAMPLE_PACKER_DROP_CNT_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         drop_cnt_o <= '0;
      end else if (drop) begin
         if (clr_i)                       drop_cnt_o <= 16'd1;
         else if (drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'd1;
      end else if (clr_i) begin
         drop_cnt_o <= '0;
      end
   end
`else
   assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_resample_packer.sv
// Directed self-checking bench for resample_packer (CH_NUM=2, DATA_WIDTH=16, FIFO_DEPTH=16).
module tb_resample_packer;

`ifdef RESAMPLE_PACKER_DROP_CNT_EN
   localparam bit DCNT = 1'b1;
`else
   localparam bit DCNT = 1'b0;
`endif

   logic                     clk = 1'b0;
   logic                     rst = 1'b1;
   logic                     en = 1'b0;
   logic                     clr = 1'b0;
   logic [15:0]              frame_len = '0;
   logic                     tvalid = 1'b0;
   logic signed [1:0][15:0]  tdata = '0;
   logic                     m_tvalid;
   logic                     m_tready = 1'b0;
   logic signed [15:0]       m_tdata;
   logic [0:0]               m_tuser;
   logic                     m_tlast;
   logic                     overflow;
   logic [15:0]              drop_cnt;

   int total = 0;
   int bad   = 0;
   logic [17:0] mon_q[$];
   logic [17:0] exp_q[$];

   resample_packer #(.CH_NUM(2), .DATA_WIDTH(16), .FIFO_DEPTH(16)) dut (
      .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr), .frame_len_i(frame_len),
      .tvalid_i(tvalid), .tdata_i(tdata), .m_tvalid_o(m_tvalid), .m_tready_i(m_tready),
      .m_tdata_o(m_tdata), .m_tuser_o(m_tuser), .m_tlast_o(m_tlast),
      .overflow_o(overflow), .drop_cnt_o(drop_cnt)
   );

   always #5 clk = ~clk;

   // Beats are captured mid-cycle; inputs only change just after the rising edge.
   always @(negedge clk) begin
      if (!rst && m_tvalid && m_tready) mon_q.push_back({m_tdata, m_tuser, m_tlast});
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic put(input logic [15:0] a, input logic [15:0] b);
      tdata[0] = a;
      tdata[1] = b;
      tvalid   = 1'b1;
      tick();
      tvalid   = 1'b0;
   endtask

   task automatic exp_smp(input logic [15:0] a, input logic [15:0] b, input logic last);
      exp_q.push_back({a, 1'b0, 1'b0});
      exp_q.push_back({b, 1'b1, last});
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick(2);
      total++;
      if (m_tvalid !== 1'b0) begin
         bad++; $display("FAIL reset_valid got=%b want=0", m_tvalid);
      end
      total++;
      if ({m_tdata, m_tuser, m_tlast, overflow, drop_cnt} !== 35'd0) begin
         bad++; $display("FAIL reset_outputs got=%h/%b/%b/%b/%h want=all zero",
                         m_tdata, m_tuser, m_tlast, overflow, drop_cnt);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic;
      mon_q.delete(); exp_q.delete();
      en = 1'b1; m_tready = 1'b1; frame_len = 16'd3;
      put(16'd1, 16'd2);
      total++;
      if (m_tvalid !== 1'b0) begin
         bad++; $display("FAIL basic_early_valid got=%b want=0", m_tvalid);
      end
      tick();
      total++;
      if ({m_tvalid, m_tdata, m_tuser} !== {1'b1, 16'sd1, 1'b0}) begin
         bad++; $display("FAIL basic_first_beat got=%b/%h/%b want=1/0001/0", m_tvalid, m_tdata, m_tuser);
      end
      tick(2); put(16'd3, 16'd4);
      tick(3); put(16'd5, 16'd6);
      tick(6);
      exp_smp(16'd1, 16'd2, 1'b0); exp_smp(16'd3, 16'd4, 1'b0); exp_smp(16'd5, 16'd6, 1'b1);
      total++;
      if (mon_q.size() != exp_q.size()) begin
         bad++; $display("FAIL basic_count got=%0d want=%0d", mon_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
         total++;
         if (mon_q[i] !== exp_q[i]) begin
            bad++; $display("FAIL basic_beat%0d got=%h want=%h", i, mon_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_overflow;
      mon_q.delete(); exp_q.delete();
      m_tready = 1'b0; frame_len = 16'd17;
      // The filler parks in the output register so the FIFO alone absorbs the burst.
      put(16'h00F0, 16'h00F1);
      tick(2);
      exp_smp(16'h00F0, 16'h00F1, 1'b0);
      for (int k = 0; k < 20; k++) begin
         tdata[0] = 16'(16'h0100 + 2 * k);
         tdata[1] = 16'(16'h0101 + 2 * k);
         tvalid   = 1'b1;
         tick();
         if (k < 16) exp_smp(16'(16'h0100 + 2 * k), 16'(16'h0101 + 2 * k), k == 15);
      end
      tvalid = 1'b0;
      total++;
      if ({overflow, drop_cnt} !== {1'b1, DCNT ? 16'd4 : 16'd0}) begin
         bad++; $display("FAIL ovf_full got=%b/%0d want=1/%0d", overflow, drop_cnt, DCNT ? 4 : 0);
      end
      total++;
      if ({m_tvalid, m_tdata} !== {1'b1, 16'sh00F0}) begin
         bad++; $display("FAIL ovf_stalled_beat got=%b/%h want=1/00f0", m_tvalid, m_tdata);
      end
      clr = 1'b1; tick(); clr = 1'b0;
      total++;
      if ({overflow, drop_cnt} !== 17'd0) begin
         bad++; $display("FAIL ovf_clr got=%b/%0d want=0/0", overflow, drop_cnt);
      end
      clr = 1'b1; tdata = {16'hDEAD, 16'hDEAD}; tvalid = 1'b1;
      tick();
      clr = 1'b0; tvalid = 1'b0;
      total++;
      if ({overflow, drop_cnt} !== {1'b1, DCNT ? 16'd1 : 16'd0}) begin
         bad++; $display("FAIL ovf_clr_vs_drop got=%b/%0d want=1/%0d", overflow, drop_cnt, DCNT ? 1 : 0);
      end
      // Writes coinciding with the draining pop are still judged against a full FIFO.
      m_tready = 1'b1; tdata = {16'h0BAD, 16'h0BAD}; tvalid = 1'b1;
      tick(2);
      tvalid = 1'b0;
      total++;
      if (drop_cnt !== (DCNT ? 16'd3 : 16'd0)) begin
         bad++; $display("FAIL ovf_pop_same_cycle got=%0d want=%0d", drop_cnt, DCNT ? 3 : 0);
      end
      tick(40);
      total++;
      if (m_tvalid !== 1'b0) begin
         bad++; $display("FAIL ovf_drained_valid got=%b want=0", m_tvalid);
      end
      total++;
      if (mon_q.size() != exp_q.size()) begin
         bad++; $display("FAIL ovf_count got=%0d want=%0d", mon_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
         total++;
         if (mon_q[i] !== exp_q[i]) begin
            bad++; $display("FAIL ovf_beat%0d got=%h want=%h", i, mon_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_stall;
      int waited;
      mon_q.delete(); exp_q.delete();
      m_tready = 1'b0; frame_len = 16'd1;
      put(16'h0055, 16'hFFAA);
      waited = 0;
      while (!m_tvalid && waited < 10) begin
         tick(); waited++;
      end
      total++;
      if (m_tvalid !== 1'b1) begin
         bad++; $display("FAIL stall_wait_valid got=%b want=1", m_tvalid);
      end
      m_tready = 1'b1; tick(); m_tready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         total++;
         if ({m_tvalid, m_tdata, m_tuser, m_tlast} !== {1'b1, 16'shFFAA, 1'b1, 1'b1}) begin
            bad++; $display("FAIL stall_hold%0d got=%b/%h/%b/%b want=1/ffaa/1/1",
                            c, m_tvalid, m_tdata, m_tuser, m_tlast);
         end
         tick();
      end
      m_tready = 1'b1;
      tick(3);
      exp_smp(16'h0055, 16'hFFAA, 1'b1);
      total++;
      if (mon_q.size() != exp_q.size()) begin
         bad++; $display("FAIL stall_count got=%0d want=%0d", mon_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
         total++;
         if (mon_q[i] !== exp_q[i]) begin
            bad++; $display("FAIL stall_beat%0d got=%h want=%h", i, mon_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_frame_len;
      mon_q.delete(); exp_q.delete();
      m_tready = 1'b1; frame_len = 16'd0;
      for (int s = 0; s < 3; s++) begin
         put(16'(16'h0200 + s), 16'(16'h0210 + s));
         tick(3);
         exp_smp(16'(16'h0200 + s), 16'(16'h0210 + s), 1'b1);
      end
      frame_len = 16'd3;
      put(16'h0300, 16'h0310);
      tick(3);
      frame_len = 16'd2;
      for (int s = 1; s < 5; s++) begin
         put(16'(16'h0300 + s), 16'(16'h0310 + s));
         tick(3);
      end
      tick(3);
      for (int s = 0; s < 5; s++) exp_smp(16'(16'h0300 + s), 16'(16'h0310 + s), (s == 2) || (s == 4));
      total++;
      if (mon_q.size() != exp_q.size()) begin
         bad++; $display("FAIL flen_count got=%0d want=%0d", mon_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
         total++;
         if (mon_q[i] !== exp_q[i]) begin
            bad++; $display("FAIL flen_beat%0d got=%h want=%h", i, mon_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_enable;
      mon_q.delete(); exp_q.delete();
      clr = 1'b1; tick(); clr = 1'b0;
      m_tready = 1'b0; frame_len = 16'd17; en = 1'b1;
      for (int s = 0; s < 17; s++) begin
         put(16'(16'h0400 + s), 16'(16'h0480 + s));
         exp_smp(16'(16'h0400 + s), 16'(16'h0480 + s), s == 16);
      end
      tick();
      en = 1'b0;
      for (int s = 0; s < 3; s++) put(16'h7777, 16'h7777);
      total++;
      if ({overflow, drop_cnt} !== 17'd0) begin
         bad++; $display("FAIL en_no_overflow got=%b/%0d want=0/0", overflow, drop_cnt);
      end
      m_tready = 1'b1;
      tick(40);
      en = 1'b1;
      total++;
      if (mon_q.size() != exp_q.size()) begin
         bad++; $display("FAIL en_count got=%0d want=%0d", mon_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
         total++;
         if (mon_q[i] !== exp_q[i]) begin
            bad++; $display("FAIL en_beat%0d got=%h want=%h", i, mon_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_reset_mid;
      m_tready = 1'b1; frame_len = 16'd4; en = 1'b1;
      put(16'h0500, 16'h0510);
      tick(3);
      m_tready = 1'b0;
      for (int s = 1; s < 7; s++) put(16'(16'h0500 + s), 16'(16'h0510 + s));
      tick();
      rst = 1'b1;
      tick();
      total++;
      if ({m_tvalid, m_tdata, m_tuser, m_tlast, overflow, drop_cnt} !== 36'd0) begin
         bad++; $display("FAIL rstmid_outputs got=%b/%h/%b/%b/%b/%h want=all zero",
                         m_tvalid, m_tdata, m_tuser, m_tlast, overflow, drop_cnt);
      end
      rst = 1'b0;
      mon_q.delete(); exp_q.delete();
      m_tready = 1'b1;
      tick(4);
      total++;
      if (m_tvalid !== 1'b0) begin
         bad++; $display("FAIL rstmid_fifo_empty got=%b want=0", m_tvalid);
      end
      frame_len = 16'd2;
      put(16'h0600, 16'h0610); tick(3);
      put(16'h0601, 16'h0611); tick(6);
      exp_smp(16'h0600, 16'h0610, 1'b0); exp_smp(16'h0601, 16'h0611, 1'b1);
      total++;
      if (mon_q.size() != exp_q.size()) begin
         bad++; $display("FAIL rstmid_count got=%0d want=%0d", mon_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
         total++;
         if (mon_q[i] !== exp_q[i]) begin
            bad++; $display("FAIL rstmid_beat%0d got=%h want=%h", i, mon_q[i], exp_q[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_stall();
      test_frame_len();
      test_enable();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
